// File: rtl/aes128.sv
// aes128 -- iterative AES-128 encryption core behind a 32-bit word-serial port.
//
// A plaintext block is loaded as four words, ten rounds run one per clock with
// round keys expanded on the fly from the fixed KEY parameter, and the
// ciphertext is then streamed out as four words on request.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous reset, active HIGH (name kept from the codebase)
//   start_n      : active-low load strobe; the sampling edge also takes word 0
//   start_read_n : active-low read strobe, honoured only in DONE
//   dword_in     : plaintext word (word 0 = state bits 127:96)
//   dword_out    : registered ciphertext word
//   done         : registered flag, ciphertext valid
//
// state | meaning
// IDLE  | waiting for a load strobe
// LOAD  | capturing plaintext words 1..3
// ROUND | AddRoundKey(0), then rounds 1..10, one per clock
// DONE  | ciphertext held, readable
// READ  | driving ciphertext words 1..3
module aes128 #(
    parameter logic [127:0] KEY = 128'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_n,
    input  logic        start_read_n,
    input  logic [31:0] dword_in,
    output logic [31:0] dword_out,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, DONE, READ} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] d, input logic [1:0] i);
        case (i)
            2'd0:    return d[127:96];
            2'd1:    return d[95:64];
            2'd2:    return d[63:32];
            default: return d[31:0];
        endcase
    endfunction

    function automatic logic [127:0] set_word(input logic [127:0] d, input logic [1:0] i,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = d;
        case (i)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [127:0]  data_q, data_d;
    logic [127:0]  rk_q, rk_d;
    logic [31:0]   dword_out_q, dword_out_d;
    logic          done_q, done_d;

    logic [127:0]  rk_next;
    logic [127:0]  round_out;
    logic [31:0]   key_t, key_n0, key_n1, key_n2, key_n3;
    logic [7:0]    sb [16];
    logic [7:0]    sr [16];
    logic [7:0]    mc [16];

    // rk_q holds the key of round rnd_q-1; derive round rnd_q's key from it.
    always_comb begin
        key_t   = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon(rnd_q), 24'h0};
        key_n0  = rk_q[127:96] ^ key_t;
        key_n1  = rk_q[95:64]  ^ key_n0;
        key_n2  = rk_q[63:32]  ^ key_n1;
        key_n3  = rk_q[31:0]   ^ key_n2;
        rk_next = {key_n0, key_n1, key_n2, key_n3};
    end

    // Byte i of the state is row i%4, column i/4.
    always_comb begin
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[data_q[127-8*i -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            round_out[127-8*i -: 8] = ((rnd_q == 4'd10) ? sr[i] : mc[i]) ^ rk_next[127-8*i -: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rnd_d       = rnd_q;
        data_d      = data_q;
        rk_d        = rk_q;
        dword_out_d = dword_out_q;
        done_d      = done_q;
        case (state_q)
            IDLE, DONE: begin
                // A load request takes priority over a read request.
                if (!start_n) begin
                    data_d  = set_word(data_q, 2'd0, dword_in);
                    done_d  = 1'b0;
                    cnt_d   = 2'd1;
                    state_d = LOAD;
                end else if (state_q == DONE && done_q && !start_read_n) begin
                    dword_out_d = get_word(data_q, 2'd0);
                    cnt_d       = 2'd1;
                    state_d     = READ;
                end
            end
            LOAD: begin
                data_d = set_word(data_q, cnt_q, dword_in);
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    rnd_d   = 4'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q == 4'd0) begin
                    data_d = data_q ^ KEY;
                    rk_d   = KEY;
                    rnd_d  = 4'd1;
                end else begin
                    data_d = round_out;
                    rk_d   = rk_next;
                    rnd_d  = rnd_q + 4'd1;
                    if (rnd_q == 4'd10) begin
                        rnd_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                dword_out_d = get_word(data_q, cnt_q);
                cnt_d       = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            rnd_q       <= 4'd0;
            data_q      <= '0;
            rk_q        <= '0;
            dword_out_q <= 32'h0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rnd_q       <= rnd_d;
            data_q      <= data_d;
            rk_q        <= rk_d;
            dword_out_q <= dword_out_d;
            done_q      <= done_d;
        end
    end

    assign dword_out = dword_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes128.sv
module tb_aes128;

    localparam logic [127:0] KEY0 = 128'h0;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;

    logic        clk;
    logic        rst;
    logic        start_n;
    logic        start_read_n;
    logic [31:0] dword_in;
    logic [31:0] dout0, dout1;
    logic        done0, done1;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_last0, exp_last1;
    logic [7:0]  sb_t [256];

    aes128 #(.KEY(KEY0)) u_dut0 (
        .clk(clk), .reset_n(rst), .start_n(start_n), .start_read_n(start_read_n),
        .dword_in(dword_in), .dword_out(dout0), .done(done0)
    );

    aes128 #(.KEY(KEY1)) u_dut1 (
        .clk(clk), .reset_n(rst), .start_n(start_n), .start_read_n(start_read_n),
        .dword_in(dword_in), .dword_out(dout1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
    task automatic build_sbox();
        logic [7:0] inv, y;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int z = 1; z < 256; z++) begin
                if (gmul(8'(x), 8'(z)) == 8'h01) inv = 8'(z);
            end
            y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb_t[x] = y;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp, wd;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_t[tmp[31:24]], sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) begin
            wd   = w[i/4];
            s[i] = pt[127-8*i -: 8] ^ wd[31-8*(i%4) -: 8];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) begin
                wd   = w[4*r + i/4];
                s[i] = s[i] ^ wd[31-8*(i%4) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drives the four plaintext words; returns at the falling edge after E0+3.
    task automatic load_words(input logic [127:0] pt, input logic both_strobes);
        @(negedge clk);
        start_n      = 1'b0;
        start_read_n = both_strobes ? 1'b0 : 1'b1;
        dword_in     = pt[127:96];
        @(negedge clk);
        start_n      = 1'b1;
        start_read_n = 1'b1;
        chk("done_drop0", {127'h0, done0}, 128'h0);
        chk("done_drop1", {127'h0, done1}, 128'h0);
        chk("hold_at_load0", {96'h0, dout0}, {96'h0, exp_last0});
        dword_in = pt[95:64];
        @(negedge clk);
        dword_in = pt[63:32];
        @(negedge clk);
        dword_in = pt[31:0];
        @(negedge clk);
        dword_in = $urandom;
    endtask

    // inject: 0 none, 1 start_n pulse in ROUND, 2 start_read_n pulse in ROUND.
    task automatic wait_done(input int inject);
        int cycles;
        cycles = 4;
        while (done0 !== 1'b1 && cycles < 40) begin
            if (cycles == 7 && inject == 1) begin
                start_n  = 1'b0;
                dword_in = $urandom;
            end
            if (cycles == 8 && inject == 2) start_read_n = 1'b0;
            @(negedge clk);
            start_n      = 1'b1;
            start_read_n = 1'b1;
            cycles++;
        end
        chk("latency", 128'(cycles), 128'd15);
        chk("done1_with_done0", {127'h0, done1}, 128'h1);
        chk("hold_at_done0", {96'h0, dout0}, {96'h0, exp_last0});
        chk("hold_at_done1", {96'h0, dout1}, {96'h0, exp_last1});
    endtask

    task automatic read_both(output logic [127:0] ct0, output logic [127:0] ct1);
        ct0 = '0;
        ct1 = '0;
        @(negedge clk);
        start_read_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start_read_n = 1'b1;
            ct0 = {ct0[95:0], dout0};
            ct1 = {ct1[95:0], dout1};
        end
        chk("done_level_after_read", {127'h0, done0}, 128'h1);
    endtask

    task automatic full_op(input logic [127:0] pt, input int inject, input logic both_strobes);
        logic [127:0] c0, c1, e0, e1;
        e0 = aes_ref(KEY0, pt);
        e1 = aes_ref(KEY1, pt);
        load_words(pt, both_strobes);
        wait_done(inject);
        read_both(c0, c1);
        chk("ct_key0", c0, e0);
        chk("ct_key1", c1, e1);
        exp_last0 = e0[31:0];
        exp_last1 = e1[31:0];
    endtask

    typedef struct {
        logic         sel;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [127:0] c0, c1, r0, r1, pt, e0;

        vecs[0] = '{1'b0, {4{32'hffffffff}}, 128'h3f5b8cc9ea855a0afa7347d23e8d664e};
        vecs[1] = '{1'b0, 128'h0,            128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[2] = '{1'b1, 128'h00112233445566778899aabbccddeeff,
                           128'h69c4e0d86a7b0430d8cdb78070b4c55a};

        build_sbox();

        rst = 1'b1; start_n = 1'b1; start_read_n = 1'b1; dword_in = 32'h0;
        exp_last0 = 32'h0; exp_last1 = 32'h0;
        #1;
        chk("reset_done", {127'h0, done0}, 128'h0);
        chk("reset_dout", {96'h0, dout0}, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Read request before any result: ignored.
        start_read_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start_read_n = 1'b1;
        chk("early_read_dout", {96'h0, dout0}, 128'h0);
        chk("early_read_done", {127'h0, done0}, 128'h0);

        // Known-answer vectors.
        for (int v = 0; v < 3; v++) begin
            load_words(vecs[v].pt, 1'b0);
            wait_done(0);
            read_both(c0, c1);
            chk($sformatf("kat%0d", v), vecs[v].sel ? c1 : c0, vecs[v].ct);
            e0 = aes_ref(KEY0, vecs[v].pt);
            chk($sformatf("kat%0d_other", v), vecs[v].sel ? c0 : c1,
                vecs[v].sel ? e0 : aes_ref(KEY1, vecs[v].pt));
            exp_last0 = e0[31:0];
            e0 = aes_ref(KEY1, vecs[v].pt);
            exp_last1 = e0[31:0];
        end

        // Two back-to-back reads give the same words.
        read_both(r0, r1);
        chk("reread_key0", r0, aes_ref(KEY0, vecs[2].pt));
        chk("reread_key1", r1, vecs[2].ct);

        // Asynchronous reset mid-ROUND.
        load_words({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midround_rst_done", {127'h0, done0}, 128'h0);
        chk("midround_rst_dout0", {96'h0, dout0}, 128'h0);
        chk("midround_rst_dout1", {96'h0, dout1}, 128'h0);
        exp_last0 = 32'h0;
        exp_last1 = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        full_op({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);

        // Strobes during ROUND are ignored.
        full_op({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
        full_op({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0);

        // New load from DONE with both strobes low: load wins.
        full_op({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);

        // Randomized operations.
        for (int n = 0; n < 20; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            full_op(pt, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
